// File: rtl/dbg_mem_arb_pkg.sv
// Shared definitions for the CPU / UART-debug memory arbiter.
package dbg_mem_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_LO   = 2'b01;
    localparam logic [1:0] WR_HI   = 2'b10;
    localparam logic [1:0] WR_BOTH = 2'b11;

endpackage

// File: rtl/dbg_req_slot.sv
// One-entry capture register for debug request pulses, with busy and sticky overrun flags.
module dbg_req_slot
    import dbg_mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dbg_cs,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_r,
    input  logic [1:0]    dbg_wr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          grant,
    output logic          busy,
    output logic          overrun,
    output logic [AW-1:0] slot_addr,
    output logic          slot_r,
    output logic [1:0]    slot_wr,
    output logic [DW-1:0] slot_wdata
);

    logic          busy_r;
    logic          overrun_r;
    logic          accept_s;
    logic [AW-1:0] addr_r;
    logic          r_r;
    logic [1:0]    wr_r;
    logic [DW-1:0] wdata_r;

    // A slot being granted this cycle frees up in time to take a new pulse.
    assign accept_s = dbg_cs & (~busy_r | grant);

    // Slot contents, occupancy and overrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            addr_r    <= '0;
            r_r       <= 1'b0;
            wr_r      <= WR_NONE;
            wdata_r   <= '0;
        end else begin
            if (accept_s) begin
                busy_r  <= 1'b1;
                addr_r  <= dbg_addr;
                r_r     <= dbg_r;
                wr_r    <= dbg_wr;
                wdata_r <= dbg_wdata;
            end else if (grant) begin
                busy_r <= 1'b0;
            end
            if (dbg_cs & busy_r & ~grant) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign busy       = busy_r;
    assign overrun    = overrun_r;
    assign slot_addr  = addr_r;
    assign slot_r     = r_r;
    assign slot_wr    = wr_r;
    assign slot_wdata = wdata_r;

endmodule

// File: rtl/dbg_mem_arb.sv
// Shares a single-port 16-bit memory between the CPU data port and the debug port.
// CPU has priority; a starvation counter forces a debug grant after MAXCPU CPU grants.
module dbg_mem_arb
    import dbg_mem_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int MAXCPU = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_r,
    input  logic [1:0]    cpu_wr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_wait,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dbg_cs,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_r,
    input  logic [1:0]    dbg_wr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_busy,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          dbg_overrun,
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    output logic          mem_r,
    output logic [1:0]    mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] MAXCPU_C = MAXCPU[3:0];

    logic          slot_busy_s;
    logic [AW-1:0] slot_addr_s;
    logic          slot_r_s;
    logic [1:0]    slot_wr_s;
    logic [DW-1:0] slot_wdata_s;
    logic          dbg_grant_s;
    logic          cpu_grant_s;
    logic [3:0]    starve_cnt_r;
    logic          rd_valid_r;
    owner_e        rd_owner_r;
    logic [DW-1:0] cpu_rdata_r;
    logic [DW-1:0] dbg_rdata_r;

    dbg_req_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .dbg_cs     (dbg_cs),
        .dbg_addr   (dbg_addr),
        .dbg_r      (dbg_r),
        .dbg_wr     (dbg_wr),
        .dbg_wdata  (dbg_wdata),
        .grant      (dbg_grant_s),
        .busy       (slot_busy_s),
        .overrun    (dbg_overrun),
        .slot_addr  (slot_addr_s),
        .slot_r     (slot_r_s),
        .slot_wr    (slot_wr_s),
        .slot_wdata (slot_wdata_s)
    );

    assign dbg_grant_s = slot_busy_s & (~cpu_cs | (starve_cnt_r == MAXCPU_C));
    assign cpu_grant_s = cpu_cs & ~dbg_grant_s;
    assign cpu_wait    = cpu_cs & ~cpu_grant_s;
    assign dbg_busy    = slot_busy_s;

    // Memory port mux: driven by the granted requester, quiet otherwise.
    always_comb begin
        mem_cs    = 1'b0;
        mem_addr  = '0;
        mem_r     = 1'b0;
        mem_wr    = WR_NONE;
        mem_wdata = '0;
        if (dbg_grant_s) begin
            mem_cs    = 1'b1;
            mem_addr  = slot_addr_s;
            mem_r     = slot_r_s;
            mem_wr    = slot_wr_s;
            mem_wdata = slot_wdata_s;
        end else if (cpu_grant_s) begin
            mem_cs    = 1'b1;
            mem_addr  = cpu_addr;
            mem_r     = cpu_r;
            mem_wr    = cpu_wr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_cs = 1'b0;
        end
    end

    // Counts CPU grants that bypass a waiting debug request.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (dbg_grant_s || !slot_busy_s) begin
            starve_cnt_r <= 4'd0;
        end else if (cpu_grant_s && (starve_cnt_r != MAXCPU_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end
    end

    // Remembers who issued the read that returns next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_owner_r <= OWN_CPU;
        end else begin
            rd_valid_r <= mem_cs & mem_r;
            rd_owner_r <= dbg_grant_s ? OWN_DBG : OWN_CPU;
        end
    end

    assign cpu_rvalid = rd_valid_r & (rd_owner_r == OWN_CPU);
    assign dbg_rvalid = rd_valid_r & (rd_owner_r == OWN_DBG);

    // Each port's read data holds its last returned word when not being updated.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_r <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_r <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_r;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_r;

endmodule

// File: tb/tb_dbg_mem_arb.sv
// Directed, table-driven bench for dbg_mem_arb with a small synchronous memory model.
module tb_dbg_mem_arb;
    import dbg_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cs, cpu_r, cpu_wait, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_wr;
    logic        dbg_cs, dbg_r, dbg_busy, dbg_rvalid, dbg_overrun;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [1:0]  dbg_wr;
    logic        mem_cs, mem_r;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic [1:0]  mem_wr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dbg_mem_arb #(.AW(16), .DW(16), .MAXCPU(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_cs(dbg_cs), .dbg_addr(dbg_addr), .dbg_r(dbg_r), .dbg_wr(dbg_wr),
        .dbg_wdata(dbg_wdata), .dbg_busy(dbg_busy), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .dbg_overrun(dbg_overrun),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_r(mem_r), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous memory, word index = addr[8:1], initial word k holds 0x5000+k.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_r) mem_rdata <= mem[mem_addr[8:1]];
            if (mem_wr[0]) mem[mem_addr[8:1]][7:0] <= mem_wdata[7:0];
            if (mem_wr[1]) mem[mem_addr[8:1]][15:8] <= mem_wdata[15:8];
        end
    end

    typedef struct packed {
        logic        cpu_wait;
        logic        mem_cs;
        logic [15:0] mem_addr;
        logic        mem_r;
        logic [1:0]  mem_wr;
        logic [15:0] mem_wdata;
        logic        dbg_busy;
        logic        cpu_rvalid;
        logic        dbg_rvalid;
        logic        dbg_overrun;
        logic [15:0] cpu_rdata;
        logic [15:0] dbg_rdata;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        ccs;
        logic [15:0] caddr;
        logic        cr;
        logic        dcs;
        logic [15:0] daddr;
        logic        dr;
        logic [1:0]  dwr;
        logic [15:0] dwd;
        obs_t        exp;
    } vec_t;

    function automatic obs_t ob(input logic w, input logic mcs, input logic [15:0] ma,
                                input logic mr, input logic [1:0] mw, input logic [15:0] mwd,
                                input logic bsy, input logic crv, input logic drv, input logic ovr,
                                input logic [15:0] crd, input logic [15:0] drd);
        obs_t o;
        o.cpu_wait = w;   o.mem_cs = mcs;   o.mem_addr = ma;   o.mem_r = mr;
        o.mem_wr = mw;    o.mem_wdata = mwd; o.dbg_busy = bsy; o.cpu_rvalid = crv;
        o.dbg_rvalid = drv; o.dbg_overrun = ovr; o.cpu_rdata = crd; o.dbg_rdata = drd;
        return o;
    endfunction

    function automatic vec_t mk(input logic rst, input logic ccs, input logic [15:0] caddr,
                                input logic cr, input logic dcs, input logic [15:0] daddr,
                                input logic dr, input logic [1:0] dwr, input logic [15:0] dwd,
                                input obs_t e);
        vec_t v;
        v.rst = rst; v.ccs = ccs; v.caddr = caddr; v.cr = cr; v.dcs = dcs;
        v.daddr = daddr; v.dr = dr; v.dwr = dwr; v.dwd = dwd; v.exp = e;
        return v;
    endfunction

    function automatic obs_t sample();
        return ob(cpu_wait, mem_cs, mem_addr, mem_r, mem_wr, mem_wdata, dbg_busy,
                  cpu_rvalid, dbg_rvalid, dbg_overrun, cpu_rdata, dbg_rdata);
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after.
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.rst; cpu_cs = v.ccs; cpu_addr = v.caddr; cpu_r = v.cr;
        cpu_wr = WR_NONE; cpu_wdata = 16'h0000;
        dbg_cs = v.dcs; dbg_addr = v.daddr; dbg_r = v.dr; dbg_wr = v.dwr; dbg_wdata = v.dwd;
        #2;
    endtask

    task automatic run(input vec_t v, input string name);
        obs_t got;
        drive(v);
        got = sample();
        tests++;
        if (got !== v.exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, v.exp);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t tbl [13];
    obs_t oz;
    vec_t idle;

    initial begin
        int g;
        logic wt, rd_at_g, ovr_at_g;
        for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
        mem[9] = 16'hBEEF;
        oz = '0;
        idle = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, oz);
        reset = 1'b1; cpu_cs = 1'b0; cpu_addr = 16'h0; cpu_r = 1'b0; cpu_wr = WR_NONE;
        cpu_wdata = 16'h0; dbg_cs = 1'b0; dbg_addr = 16'h0; dbg_r = 1'b0; dbg_wr = WR_NONE;
        dbg_wdata = 16'h0;

        // Debug read while CPU idle, then CPU reads starving a debug write.
        tbl[0]  = idle;
        tbl[1]  = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0012, 1'b1, WR_NONE, 16'h0, oz);
        tbl[2]  = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b0, 1'b1, 16'h0012, 1'b1, WR_NONE, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
        tbl[3]  = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'hBEEF));
        tbl[4]  = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hBEEF));
        tbl[5]  = mk(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0100, 1'b0, WR_HI, 16'hAB00,
                     ob(1'b0, 1'b1, 16'h0040, 1'b1, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hBEEF));
        for (int i = 0; i < 4; i++)
            tbl[6+i] = mk(1'b0, 1'b1, 16'h0042 + 16'(2*i), 1'b1, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                          ob(1'b0, 1'b1, 16'h0042 + 16'(2*i), 1'b1, WR_NONE, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                             16'h5020 + 16'(i), 16'hBEEF));
        tbl[10] = mk(1'b0, 1'b1, 16'h004A, 1'b1, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b1, 1'b1, 16'h0100, 1'b0, WR_HI, 16'hAB00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5024, 16'hBEEF));
        tbl[11] = mk(1'b0, 1'b1, 16'h004A, 1'b1, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b0, 1'b1, 16'h004A, 1'b1, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5024, 16'hBEEF));
        tbl[12] = mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
                     ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5025, 16'hBEEF));

        // Reset held three cycles while debug pulses arrive.
        drive(mk(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0012, 1'b1, WR_NONE, 16'h0, oz));
        drive(mk(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0014, 1'b1, WR_NONE, 16'h0, oz));
        run(mk(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0016, 1'b1, WR_NONE, 16'h0, oz), "reset_hold");
        run(idle, "reset_release");

        for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // Second pulse while busy is dropped; the first request completes.
        run(mk(1'b0, 1'b1, 16'h0060, 1'b1, 1'b1, 16'h0100, 1'b1, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0060, 1'b1, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5025, 16'hBEEF)), "ovr_c0");
        run(mk(1'b0, 1'b1, 16'h0060, 1'b1, 1'b1, 16'h0012, 1'b1, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0060, 1'b1, WR_NONE, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5030, 16'hBEEF)), "ovr_c1");
        g = 0; wt = 1'b0; rd_at_g = 1'b0; ovr_at_g = 1'b0;
        for (int k = 2; k < 12; k++) begin
            drive(mk(1'b0, 1'b1, 16'h0060, 1'b1, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, oz));
            if (mem_cs && mem_addr == 16'h0100) begin
                g = k; wt = cpu_wait; rd_at_g = mem_r; ovr_at_g = dbg_overrun;
                break;
            end
        end
        chk("starve_grant_cycle", 16'(g), 16'd5);
        chk("starve_cpu_wait", {15'h0, wt}, 16'h0001);
        chk("starve_mem_r", {15'h0, rd_at_g}, 16'h0001);
        chk("overrun_set", {15'h0, ovr_at_g}, 16'h0001);
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5030, 16'hAB80)), "ovr_rdata");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5030, 16'hAB80)), "ovr_sticky");

        // CPU read then debug read on the next cycle: no cross-steering.
        run(mk(1'b0, 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0002, 1'b1, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0050, 1'b1, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5030, 16'hAB80)), "b2b_n");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0002, 1'b1, WR_NONE, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5028, 16'hAB80)), "b2b_n1");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5028, 16'h5001)), "b2b_n2");

        // Reset with a pending request and an in-flight read.
        run(mk(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0012, 1'b1, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0040, 1'b1, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5028, 16'h5001)), "midrst_pre");
        drive(mk(1'b1, 1'b1, 16'h0042, 1'b1, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, oz));
        run(idle, "midrst_post0");
        run(idle, "midrst_post1");

        // New pulse in the same cycle the pending entry is granted.
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 1'b0, WR_LO, 16'h00CD, oz), "refill_m0");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 1'b1, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0004, 1'b0, WR_LO, 16'h00CD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0)), "refill_m1");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b1, 16'h0004, 1'b1, WR_NONE, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0)), "refill_m2");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h50CD)), "refill_m3");
        run(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0,
               ob(1'b0, 1'b0, 16'h0, 1'b0, WR_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h50CD)), "refill_m4");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dbg_mem_arb.md
Name: dbg_mem_arb

Overview:
- Arbitrates one single-port synchronous 16-bit memory between the b16 CPU data port and the UART debug port.
- The debug port issues one-cycle request pulses. The block latches each pulse into a one-entry pending slot, so a debug request is never lost while the CPU owns the memory.
- The CPU has default priority. A starvation counter forces a debug grant after MAXCPU consecutive CPU grants while debug is pending.
- Read data returns one cycle after grant and is steered to the requester that issued the read.

Parameters:
AW, 16, address width (word-of-bytes address; bit 0 selects byte lane)
DW, 16, data width
MAXCPU, 4, max consecutive CPU grants while a debug request is pending (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_cs  in  1  CPU access request (level; held until granted)
cpu_addr  in  AW  CPU address
cpu_r  in  1  CPU read
cpu_wr  in  2  CPU byte write enables {hi,lo}
cpu_wdata  in  DW  CPU write data
cpu_wait  out  1  CPU request not granted this cycle
cpu_rdata  out  DW  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (pulse)
dbg_cs  in  1  debug request pulse (one cycle)
dbg_addr  in  AW  debug address
dbg_r  in  1  debug read
dbg_wr  in  2  debug byte write enables
dbg_wdata  in  DW  debug write data
dbg_busy  out  1  pending slot occupied
dbg_rdata  out  DW  debug read data
dbg_rvalid  out  1  dbg_rdata valid (pulse)
dbg_overrun  out  1  sticky: a debug pulse arrived while busy
mem_cs  out  1  memory select
mem_addr  out  AW  memory address
mem_r  out  1  memory read
mem_wr  out  2  memory byte write enables
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid cycle after mem_cs&mem_r

Behaviour:
- Reset (sync, active-high):
  - Clears the pending slot, starvation count, read-owner, and dbg_overrun.
  - All outputs read 0 in the cycle after reset is sampled: cpu_wait, cpu_rvalid, dbg_rvalid, dbg_busy, dbg_overrun, mem_cs, mem_r, mem_wr. Data outputs are also 0.
  - A reset mid-operation drops any pending debug request and any in-flight read; no rvalid fires.
- Pending slot:
  - A dbg_cs pulse with the slot empty captures addr/r/wr/wdata. dbg_busy rises the next cycle.
  - dbg_cs with the slot full is dropped and sets dbg_overrun, which stays set until reset.
  - dbg_cs in the same cycle the slot is granted is accepted: the slot is refilled next cycle.
- Arbitration (combinational, from registered state):
  - Debug is granted when the slot is full AND (cpu_cs=0 OR starve_cnt==MAXCPU). Otherwise cpu_cs is granted.
  - cpu_wait = cpu_cs & ~cpu_grant.
  - mem_cs/addr/r/wr/wdata are driven from the granted requester. All are 0 when there is no grant.
- Starvation counter:
  - Increments on a CPU grant while the slot is full, saturating at MAXCPU.
  - Clears on a debug grant or when the slot is empty.
- Read return:
  - A granted read registers the owner (CPU/DBG) and sets a valid flag.
  - On the next cycle: rvalid pulses for that owner and rdata = mem_rdata. The non-owner's rdata holds its last value.
  - Back-to-back reads to different owners are permitted, one per cycle.
- Write-only grants (r=0, wr≠0) produce no rvalid.
- r=1 with wr≠0 is illegal. It is forwarded unchanged; read and write take effect, and data for the write is undefined.
- A request with r=0 and wr=0 is granted and consumes a slot but performs no memory action.
- Latency:
  - CPU uncontended: grant in the same cycle; read data +1 cycle.
  - Debug: worst case MAXCPU+1 cycles from dbg_busy rising to grant.

Decomposition:
- Shared package: AW/DW defaults; owner encoding (OWN_CPU=0, OWN_DBG=1); write-enable constants WR_NONE=2'b00, WR_LO=2'b01, WR_HI=2'b10, WR_BOTH=2'b11.
- One natural sub-module, dbg_req_slot: the one-entry capture register with busy/overrun logic. Arbitration and read steering stay in the top module.

Test Plan:
1. Reset is held 3 cycles while dbg_cs pulses -> dbg_busy=0, no mem_cs, dbg_overrun=0 after release.
2. CPU idle; dbg read pulse addr=0x0012; memory returns 0xBEEF -> mem_cs one cycle after the pulse, dbg_rvalid one cycle later, dbg_rdata=0xBEEF, cpu_rvalid=0.
3. CPU issues continuous reads; dbg write pulse addr=0x0100, wr=2'b10, data=0xAB00, MAXCPU=4 -> CPU is granted 4 consecutive cycles, the 5th cycle grants debug with mem_wr=2'b10 and cpu_wait=1 for that cycle only.
4. Second dbg_cs while busy -> request dropped, dbg_overrun=1 and stays 1 until reset; the first request completes normally.
5. CPU read at cycle n, debug read granted at cycle n+1 -> cpu_rvalid at n+1 and dbg_rvalid at n+2, each with the matching mem_rdata and no cross-steering.
6. dbg_cs in the same cycle its pending entry is granted -> the new entry is captured, dbg_busy stays 1, and no overrun is flagged.
